// File: rtl/parity_pkg.sv
// Shared types and constants for the parity serial transmit controller.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_W_DEF = 5;
  localparam int FRAME_W    = DATA_W_DEF + 1;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/even_parity.sv
// Combinational frame former: {data, parity}. Define PARITY_ODD_EN for odd parity.
module even_parity #(
  parameter int DATA_W = 5
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W:0]   o_frame
);

  logic w_par;

`ifdef PARITY_ODD_EN
  assign w_par = ~(^i_data);
`else
  assign w_par = ^i_data;
`endif

  assign o_frame = {i_data, w_par};

endmodule

// File: rtl/parity_tx_ctrl.sv
// Serial transmitter: start bit, {data, parity} MSB-first, stop bit, BIT_CYCLES clocks per bit.
// Parity sense selected by PARITY_ODD_EN (undefined: even parity).
module parity_tx_ctrl
  import parity_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic [DATA_W:0]   frame_out,
  output logic              done
);

  localparam int FW = DATA_W + 1;
  localparam int CW = clog2_min1(BIT_CYCLES);
  localparam int IW = clog2_min1(FW);
  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MSB = IW'(DATA_W);

  tx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_idx;
  logic [DATA_W:0] r_frame;
  logic            r_tx;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;

  logic [DATA_W:0] w_frame;
  logic [IW-1:0]   w_idx_dec;

  even_parity #(.DATA_W(DATA_W)) u_par (
    .i_data  (in_data),
    .o_frame (w_frame)
  );

  assign w_idx_dec = r_idx - IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_frame <= '0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid && r_ready) begin
            r_frame <= w_frame;
            r_state <= START;
            r_cnt   <= CNT_MAX;
            r_tx    <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (r_cnt == '0) begin
            r_state <= DATA;
            r_idx   <= IDX_MSB;
            r_cnt   <= CNT_MAX;
            r_tx    <= r_frame[DATA_W];
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DATA: begin
          if (r_cnt == '0) begin
            r_cnt <= CNT_MAX;
            if (r_idx == '0) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_idx <= w_idx_dec;
              r_tx  <= r_frame[w_idx_dec];
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        STOP: begin
          // Done is raised on the edge back to IDLE so it coincides with in_ready rising.
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_out    = r_tx;
  assign in_ready  = r_ready;
  assign busy      = r_busy;
  assign frame_out = r_frame;
  assign done      = r_done;

endmodule

// File: tb/tb_parity_tx_ctrl.sv
// Directed bench for parity_tx_ctrl (DATA_W=5, BIT_CYCLES=4).
module tb_parity_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_ready;
  logic       tx_out;
  logic       busy;
  logic [5:0] frame_out;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  parity_tx_ctrl #(.DATA_W(5), .BIT_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .tx_out    (tx_out),
    .busy      (busy),
    .frame_out (frame_out),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after the accepting edge; checks cycles 0..31 of the frame and the done cycle.
  task automatic check_frame(input logic [5:0] expf);
    logic exp_tx;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k < 4)       exp_tx = 1'b0;
      else if (k < 28) exp_tx = expf[5 - (k / 4 - 1)];
      else             exp_tx = 1'b1;
      chk($sformatf("tx_c%0d", k), {31'd0, tx_out}, {31'd0, exp_tx});
      chk($sformatf("ctl_c%0d", k), {29'd0, busy, in_ready, done}, {29'd0, 3'b100});
      if (k == 0) chk("frame", {26'd0, frame_out}, {26'd0, expf});
    end
    @(negedge clk);
    chk("done_cyc", {28'd0, done, busy, in_ready, tx_out}, {28'd0, 4'b1011});
    chk("frame_hold", {26'd0, frame_out}, {26'd0, expf});
  endtask

  logic [5:0] odd_or_even;

  initial begin
`ifdef PARITY_ODD_EN
    odd_or_even = 6'b011010;
`else
    odd_or_even = 6'b011011;
`endif
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_vals", {25'd0, frame_out, tx_out, in_ready, busy, done}, {25'd0, 6'd0, 4'b1100});
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle", {28'd0, tx_out, in_ready, busy, done}, {28'd0, 4'b1100});
    end

    // Single word 01101
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 5'b01101;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check_frame(odd_or_even);
    @(negedge clk);
    chk("done_clr", {31'd0, done}, 32'd0);

`ifndef PARITY_ODD_EN
    // Back-to-back with valid held high; second word presented during first frame
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 5'b01010;
    @(posedge clk);
    #1 in_data = 5'b01111;
    check_frame(6'b010100);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check_frame(6'b011110);

    // Reset during DATA bit 3 of 10001
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 5'b10001;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_rst_frame", {26'd0, frame_out}, {26'd0, 6'b100010});
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {25'd0, frame_out, tx_out, busy, in_ready, done}, {25'd0, 6'd0, 4'b1010});
    repeat (2) begin
      @(negedge clk);
      chk("rst_nodone", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_nodone", {31'd0, done}, 32'd0);
    end
    in_valid = 1'b1;
    in_data  = 5'b00000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check_frame(6'b000000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/parity_tx_ctrl.md
Name: parity_tx_ctrl

Overview:
- Serial transmit controller around the even-parity generator.
- Accepts DATA_W-bit words on a valid/ready handshake and forms frame = {data, parity}, with parity at bit 0.
- Serialises the frame as: start bit, frame MSB-first, stop bit, each bit held BIT_CYCLES clocks.
- Sits between a word producer and a single-wire link; only one frame is in flight at a time.

Parameters:
- DATA_W, 5, payload width; frame width is DATA_W+1.
- BIT_CYCLES, 4, clocks per serial bit; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a word.
- in_data  in  DATA_W  payload word.
- in_ready  out  1  controller can accept a word.
- tx_out  out  1  serial line; idles high.
- busy  out  1  frame in progress.
- frame_out  out  DATA_W+1  latched {data, parity} of the current or last frame.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset values: tx_out=1, in_ready=1, busy=0, done=0, frame_out=0, state=IDLE, all counters 0.
- Reset is asynchronous; asserting it mid-frame aborts immediately, the frame is discarded and no done pulse is produced.
- Parity is XOR of in_data (even parity), so the frame always has an even number of 1s.
- FSM states are IDLE, START, DATA, STOP.
- IDLE: in_ready=1, busy=0. On in_valid&&in_ready, latch frame_out={in_data, parity} and go to START.
- START: tx_out=0 for BIT_CYCLES clocks, then go to DATA with bit index = DATA_W.
- DATA: tx_out=frame_out[idx]. After BIT_CYCLES clocks, decrement idx. After idx 0 completes, go to STOP.
- STOP: tx_out=1 for BIT_CYCLES clocks. On the last STOP cycle assert done for one clock, then go to IDLE.
- Latency: tx_out falls on the first clock edge after the handshake.
- Frame duration: (DATA_W+3)*BIT_CYCLES clocks from START entry to IDLE.
- in_ready=0 outside IDLE. in_data and in_valid are ignored while busy.
- Back-to-back words have a minimum of 1 IDLE cycle between STOP and the next START.
- Bit counter: BIT_CYCLES-1 down to 0, reloaded on every bit boundary. BIT_CYCLES=1 gives one clock per bit with no stall.
- frame_out holds its value after done until the next accept.
- Outputs are registered; tx_out is glitch-free.

Optional Feature:
- Macro: PARITY_ODD_EN.
- Defined: parity = ~XOR(in_data), giving odd parity; frame format and timing are unchanged.
- Undefined: even parity as above.

Decomposition:
- Shared package parity_pkg holds:
  - FSM state typedef tx_state_t (IDLE, START, DATA, STOP), 2-bit encoding.
  - Localparam FRAME_W = DATA_W+1.
- Sub-module even_parity (combinational): data in, {data, parity} out.
  - Instantiated once; the PARITY_ODD_EN inversion is applied inside it.

Test Plan:
- Reset, idle, in_valid=0: tx_out=1, in_ready=1, busy=0, done=0 for 20 cycles.
- Send data=5'b01101, BIT_CYCLES=4:
  - frame_out=6'b011011.
  - Line sequence 0,0,1,1,0,1,1,1, each bit 4 clocks.
  - done pulses at cycle 32 after START entry.
- Send 5'b01010 then 5'b01111 with in_valid held high:
  - frames 6'b010100 and 6'b011110.
  - exactly 1 IDLE cycle between frames.
  - in_ready=0 throughout each frame.
- Assert rst_n=0 during DATA bit 3 of 5'b10001:
  - tx_out=1 and busy=0 asynchronously, no done pulse.
  - the next word 5'b00000 transmits cleanly as frame 6'b000000.
- Build with PARITY_ODD_EN, send 5'b01101: frame_out=6'b011010, timing identical to the even-parity case.
